// File: rtl/uart_rx_ctrl_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t           - receive FSM state encoding
//   UART_DATA_BITS            - data bits per frame (8)
//   UART_DEFAULT_CLKS_PER_BIT - 25 MHz / 115200 baud
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state (8E1 frame).
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: received-byte bus from the UART receiver to its consumer.
//   rx_data       - last good byte (held until the next good byte)
//   rx_valid      - one-cycle strobe, rx_data updated this cycle
//   rx_frame_err  - one-cycle strobe, stop bit sampled low
//   rx_parity_err - one-cycle strobe, parity mismatch (UART_RX_PARITY_EN only)
//   rx_busy       - receiver not idle
//   rx_state      - debug view of the receive FSM state
// Handshake: valid-only, no ready. The consumer must capture rx_data in the
// cycle rx_valid is high; there is no backpressure and no retry.
// Modports: master = receiver (drives), slave = consumer (observes).
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                      rx_parity_err;
`endif
  logic                      rx_busy;
  uart_rx_state_t            rx_state;

  modport master (
    output rx_data, rx_valid, rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output rx_parity_err,
`endif
    output rx_busy, rx_state
  );

  modport slave (
    input rx_data, rx_valid, rx_frame_err,
`ifdef UART_RX_PARITY_EN
    input rx_parity_err,
`endif
    input rx_busy, rx_state
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for asynchronous pin inputs.
//   clk, rst - destination clock, synchronous active-high reset
//   d_i      - asynchronous input
//   q_o      - synchronised output, 2 cycles of latency
// RST_VAL sets the reset value of both flops (the idle level of the pin).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer (8N1, or 8E1 with UART_RX_PARITY_EN).
//   clk   - system clock
//   rst   - synchronous active-high reset
//   rxd   - raw UART line, asynchronous, idle high
//   rx_if - uart_rx_ctrl_if.master: byte, strobes, busy and FSM debug state
// The start bit is confirmed at its centre; every later bit (data, parity,
// stop) is sampled exactly CLKS_PER_BIT cycles after the previous sample.
// Build macro: UART_RX_PARITY_EN adds the even-parity bit and rx_parity_err.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_ctrl_if.master rx_if
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxs;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end

      ST_START: begin
        // Mid start bit: a line that has gone high again was a glitch.
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          par_d     = rxs;
          state_d   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit of margin to catch a
        // back-to-back start edge.
        if (clk_cnt_q == FULL_CNT) begin
          clk_cnt_d = '0;
          if (rxs) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            // Even parity: data plus parity bit must hold an even count of ones.
            parity_err_d = ^{shift_q, par_q};
`endif
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Absorb a break: wait for the line to return high before hunting.
        clk_cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_data       = rx_data_q;
  assign rx_if.rx_valid      = rx_valid_q;
  assign rx_if.rx_frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.rx_parity_err = parity_err_q;
`endif
  assign rx_if.rx_busy       = busy_q;
  assign rx_if.rx_state      = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with CLKS_PER_BIT = 16.
// Build macro: UART_RX_PARITY_EN selects the 8E1 frame and parity checks.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W = 10;  // {frame_err, parity_err, data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rx_if (rx_if)
  );

  logic perr;
`ifdef UART_RX_PARITY_EN
  assign perr = rx_if.rx_parity_err;
`else
  assign perr = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           valid_cyc_q[$];
  int           n_checks  = 0;
  int           n_fail    = 0;
  int           valid_cnt = 0;
  int           ferr_cnt  = 0;
  int           exp_valid = 0;
  logic [7:0]   last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid && rx_if.rx_frame_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL exclusive: rx_valid and rx_frame_err both high (t=%0t)", $time);
      end
      if (rx_if.rx_valid || rx_if.rx_frame_err || perr) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got 0x%0h, expected no pulse (t=%0t)",
                   {rx_if.rx_frame_err, perr, rx_if.rx_data}, $time);
        end else begin
          check("frame_result", {22'd0, rx_if.rx_frame_err, perr, rx_if.rx_data},
                {22'd0, exp_q.pop_front()});
        end
        if (rx_if.rx_valid) begin
          valid_cnt++;
          valid_cyc_q.push_back(cyc);
        end
        if (rx_if.rx_frame_err) ferr_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  // All line changes happen 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame with a high stop bit delivers its byte (parity
  // error when data plus parity bit has odd weight); a low stop bit reports a
  // framing error and leaves the held byte untouched.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    logic pe;
    pe = (P == 1) ? (^{d, par}) : 1'b0;
    if (stop) begin
      exp_q.push_back({1'b0, pe, d});
      last_good = d;
      exp_valid++;
    end else begin
      exp_q.push_back({1'b1, 1'b0, last_good});
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (P == 1) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int v0;
    int f0;
    int lat;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",  rx_if.rx_data, 8'h00);
    check("reset_valid", rx_if.rx_valid, 1'b0);
    check("reset_ferr",  rx_if.rx_frame_err, 1'b0);
    check("reset_busy",  rx_if.rx_busy, 1'b0);
    check("reset_state", 32'(rx_if.rx_state), 32'(ST_IDLE));
    rst = 1'b0;
    idle(4);

    // 1. Single 0x55 with exact latency: 2 sync + 1 IDLE + half bit to the
    //    start sample + 1, then (8 data [+ parity] + stop) bits, output register.
    v0 = valid_cnt;
    c0 = cyc;
    send_frame(8'h55, 1'b1, even_par(8'h55));
    check("t1_valid_count", valid_cnt, v0 + 1);
    check("t1_data", rx_if.rx_data, 8'h55);
    check("t1_busy_after_stop", rx_if.rx_busy, 1'b0);
    lat = 4 + (C - 1) / 2 + (9 + P) * C;
    if (valid_cyc_q.size() > 0) check("t1_latency", valid_cyc_q[$] - c0, lat);
    else check("t1_latency_seen", 0, 1);
    idle(5);

    // 2. Back-to-back 0xA5, 0x3C with no gap.
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    send_frame(8'h3C, 1'b1, even_par(8'h3C));
    check("t2_valid_count", valid_cnt, v0 + 2);
    check("t2_data", rx_if.rx_data, 8'h3C);
    if (valid_cyc_q.size() >= 2)
      check("t2_spacing", valid_cyc_q[$] - valid_cyc_q[$-1], (10 + P) * C);
    else check("t2_spacing_seen", 0, 1);
    idle(5);

    // 3. Five-cycle glitch on the line.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t3_busy_in_start", rx_if.rx_busy, 1'b1);
    idle(3 * C);
    check("t3_busy_back_idle", rx_if.rx_busy, 1'b0);
    check("t3_no_valid", valid_cnt, v0);
    check("t3_no_ferr", ferr_cnt, f0);
    check("t3_data_held", rx_if.rx_data, 8'h3C);

    // 4. Break: 0x00 with low stop, line low 40 more cycles, then 0x81.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t4_ferr_count", ferr_cnt, f0 + 1);
    check("t4_no_valid", valid_cnt, v0);
    check("t4_busy_wait_idle", rx_if.rx_busy, 1'b1);
    check("t4_data_held", rx_if.rx_data, 8'h3C);
    idle(4);
    check("t4_busy_released", rx_if.rx_busy, 1'b0);
    idle(C);
    send_frame(8'h81, 1'b1, even_par(8'h81));
    check("t4_data_after", rx_if.rx_data, 8'h81);
    check("t4_valid_after", valid_cnt, v0 + 1);
    idle(5);

    // 5. Reset in the middle of data bit 4 of 0xFF.
    v0 = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    check("t5_data_reset", rx_if.rx_data, 8'h00);
    check("t5_busy_reset", rx_if.rx_busy, 1'b0);
    check("t5_valid_reset", rx_if.rx_valid, 1'b0);
    check("t5_ferr_reset", rx_if.rx_frame_err, 1'b0);
    idle(2 * C);
    check("t5_no_pulse", valid_cnt, v0);
    send_frame(8'h12, 1'b1, even_par(8'h12));
    check("t5_data_after", rx_if.rx_data, 8'h12);
    idle(5);

`ifdef UART_RX_PARITY_EN
    // 6. Parity good then bad on 0x07.
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    check("t6_valid_count", valid_cnt, v0 + 2);
    check("t6_data", rx_if.rx_data, 8'h07);
    idle(5);
`endif

    // 7. Random frames with random gaps; parity bit sometimes wrong.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       pb;
      d  = 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 3) == 0) ? ~even_par(d) : even_par(d);
      send_frame(d, 1'b1, pb);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, C));
    end
    idle(2 * C);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid_total", valid_cnt, exp_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
